// File: rtl/beeb_mem_pkg.sv
// Shared SRAM timing constants and arbiter state encoding
// for the BBC external memory subsystem.
package beeb_mem_pkg;

  localparam int SRAM_ADDR_W    = 18;
  localparam int SRAM_DATA_W    = 8;
  localparam int ACC_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD
  } state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the 256K x 8 async SRAM: A has priority,
// B is protected from starvation by a bounded grant counter.
module sram_arbiter
  import beeb_mem_pkg::*;
#(
  parameter int ACC_CYCLES     = ACC_CYCLES_DEF,
  parameter int B_STARVE_LIMIT = 4,
  parameter int ADDR_W         = SRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [SRAM_DATA_W-1:0] a_wdata,
  output logic                   a_ack,
  output logic [SRAM_DATA_W-1:0] a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [SRAM_DATA_W-1:0] b_wdata,
  output logic                   b_ack,
  output logic [SRAM_DATA_W-1:0] b_rdata,
  output logic                   sram_cs_b,
  output logic                   sram_oe_b,
  output logic                   sram_we_b,
  output logic [ADDR_W-1:0]      sram_a,
  output logic [SRAM_DATA_W-1:0] sram_dout,
  output logic                   sram_dout_en,
  input  logic [SRAM_DATA_W-1:0] sram_din,
  output logic                   grant_b,
  output logic                   busy
);

  localparam logic [3:0] LIMIT    = 4'(B_STARVE_LIMIT);
  localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

  state_t state, state_d;
  logic [3:0] acnt, acnt_d;
  logic [3:0] starve, starve_d;
  logic we_q, we_d;
  logic gb_d;
  logic [ADDR_W-1:0] addr_d;
  logic [SRAM_DATA_W-1:0] dout_d;
  logic pick_a, pick_b;
  logic cap;

  always_comb begin
    pick_b   = b_req && (starve == LIMIT || !a_req);
    pick_a   = a_req && !pick_b;
    state_d  = state;
    acnt_d   = acnt;
    starve_d = starve;
    we_d     = we_q;
    gb_d     = grant_b;
    addr_d   = sram_a;
    dout_d   = sram_dout;
    cap      = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          pick_a: begin
            state_d = SETUP;
            we_d    = a_we;
            addr_d  = a_addr;
            dout_d  = a_wdata;
            gb_d    = 1'b0;
            if (!b_req)
              starve_d = '0;
            else if (starve != LIMIT)
              starve_d = starve + 4'd1;
          end
          pick_b: begin
            state_d  = SETUP;
            we_d     = b_we;
            addr_d   = b_addr;
            dout_d   = b_wdata;
            gb_d     = 1'b1;
            starve_d = '0;
          end
          default: ;
        endcase
      end
      SETUP: begin
        state_d = ACTIVE;
        acnt_d  = ACC_LAST;
      end
      ACTIVE: begin
        if (acnt == '0) begin
          state_d = HOLD;
          cap     = !we_q;
        end else begin
          acnt_d = acnt - 4'd1;
        end
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every pin is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      acnt         <= '0;
      starve       <= '0;
      we_q         <= 1'b0;
      grant_b      <= 1'b0;
      sram_a       <= '0;
      sram_dout    <= '0;
      sram_cs_b    <= 1'b1;
      sram_oe_b    <= 1'b1;
      sram_we_b    <= 1'b1;
      sram_dout_en <= 1'b0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      acnt         <= acnt_d;
      starve       <= starve_d;
      we_q         <= we_d;
      grant_b      <= gb_d;
      sram_a       <= addr_d;
      sram_dout    <= dout_d;
      sram_cs_b    <= state_d == IDLE;
      sram_oe_b    <= !(!we_d && (state_d == SETUP ||
                                  state_d == ACTIVE));
      sram_we_b    <= !(we_d && state_d == ACTIVE);
      sram_dout_en <= we_d && state_d != IDLE;
      a_ack        <= state_d == HOLD && !gb_d;
      b_ack        <= state_d == HOLD && gb_d;
      busy         <= state_d != IDLE;
      if (cap && !grant_b)
        a_rdata <= sram_din;
      if (cap && grant_b)
        b_rdata <= sram_din;
    end
  end

endmodule
